coil_pwm_driver: RTL and testbench
==================================

COIL_PWM_DRIVER -- requirements
Module: coil_pwm_driver

Interface
REQ-001 SHALL have parameter PRESC_DIV, default 4: clk cycles per PWM tick (legal 2..1024).
REQ-002 SHALL have port clk  input  1  rising-edge system clock.
REQ-003 SHALL have port rst  input  1  reset: asynchronous, active-high.
REQ-004 SHALL have port en  input  1  1 = run PWM; 0 = outputs low, counters idle.
REQ-005 SHALL have ports duty_a, duty_b, duty_c, duty_d  input  8 each  requested coil duty (0..255), driven by the stepper state machine.
REQ-006 SHALL have ports pwm_a, pwm_b, pwm_c, pwm_d  output  1 each  registered coil drive.
REQ-007 SHALL have port period_start  output  1  one-clk pulse marking a shadow load and period start.
REQ-008 SHALL have port fault  output  1  sticky interlock fault flag.
REQ-009 SHALL have port fault_clr  input  1  synchronous clear request for fault.

Function
REQ-010 SHALL contain a prescaler counting 0..PRESC_DIV-1 while en=1 and generating a tick on the cycle it equals PRESC_DIV-1.
REQ-011 SHALL contain an 8-bit period counter that advances on each tick and wraps 255->0 with no terminal hold.
REQ-012 SHALL hold four 8-bit shadow duty registers, loaded from duty_a..d only at load events; duty inputs SHALL have no effect between loads.
REQ-013 Load event SHALL be (a) the first clk edge with en=1 after en=0 or after reset, or (b) the tick on which the period counter wraps 255->0.
REQ-014 period_start SHALL be 1 for exactly the one clk cycle following each load edge and 0 otherwise.
REQ-015 Each pwm_x SHALL be high exactly while period_counter < shadow_x, so one period (256*PRESC_DIV clk) contains shadow_x*PRESC_DIV high cycles.
REQ-016 duty 0 SHALL give a constant low output; duty 255 SHALL give 255*PRESC_DIV high cycles per period, never 100%.
REQ-017 pwm_x SHALL go high in the same cycle as period_start when shadow_x != 0, with 1 clk registered latency from the counter/shadow state.
REQ-018 Interlock: if a load captures nonzero values for both A and C, pwm_a and pwm_c SHALL stay low for that whole period; B/D SHALL be handled the same way, independently.
REQ-019 Any interlock violation at a load SHALL set fault in the cycle period_start asserts.
REQ-020 fault SHALL clear one cycle after fault_clr=1 unless a violation is detected on the same edge, in which case set wins.
REQ-021 A non-violating pair SHALL continue normal PWM while the other pair is interlocked.
REQ-022 On en 1->0: all pwm_x SHALL be 0 from the next cycle, prescaler and period counter SHALL be 0, shadows SHALL be 0, period_start SHALL be 0, and fault SHALL be retained.
REQ-023 On en 0->1: the rising-edge cycle SHALL be a load (REQ-013a) with the counter starting at 0.

Reset
REQ-024 rst=1 SHALL asynchronously force pwm_a..d=0, period_start=0, fault=0, and clear the prescaler, period counter and shadows to 0.
REQ-025 After rst release, the first edge with en=1 SHALL be a load event.
REQ-026 Reset mid-period SHALL abandon the period; no partial pulse SHALL follow release until the next load.

Verification (PRESC_DIV=4)
REQ-027 Stimulus: en=1, duty_a=64, others 0 -> pwm_a high 256 of every 1024 clk; period_start every 1024 clk; fault=0.
REQ-028 Stimulus: duty_b=0 and duty_d=255 -> pwm_b never high; pwm_d high 1020 of 1024, low during counter 255.
REQ-029 Stimulus: duty_a 64->128 at counter=20 -> current period keeps 256 high cycles; the next period after period_start gives 512.
REQ-030 Stimulus: duty_a=10, duty_c=10, duty_b=50 -> pwm_a and pwm_c low for the full period, pwm_b 200 high, fault=1; fault_clr with duty_c=0 pending -> fault=0 after clear; fault_clr on a violating load edge -> fault stays 1.
REQ-031 Stimulus: en dropped at counter=100 with duty_a=200 -> pwm_a=0 the next cycle; en raised 5 cycles later -> period_start the next cycle and a fresh 800-cycle pulse.
REQ-032 Stimulus: rst asserted asynchronously mid-pulse (not on a clk edge) -> all outputs 0 immediately; after release with en=1 -> first load, then normal PWM.

Source files
------------

// File: rtl/coil_pwm_driver.sv
// -----------------------------------------------------------------------------
// coil_pwm_driver
//
// Four-channel PWM generator for a stepper motor's coil drivers.
// A prescaler divides clk down to PWM ticks. An 8-bit period counter advances
// once per tick, so one PWM period is 256*PRESC_DIV clk cycles. The duty inputs
// are captured into shadow registers only at period boundaries (load events),
// so the stepper state machine can change them at any time without glitching
// the current period.
//
// Coils A/C and B/D are opposing windings. If a load captures a nonzero duty
// for both coils of a pair, that pair is held off for the whole period and the
// sticky fault flag is set. The other pair keeps running normally.
//
// Ports
//   clk              rising-edge system clock
//   rst              asynchronous, active-high reset
//   en               1 = run PWM, 0 = outputs low and counters idle
//   duty_a..duty_d   requested coil duty 0..255
//   pwm_a..pwm_d     registered coil drive outputs
//   period_start     one-clk pulse in the first cycle of each period (shadow load)
//   fault            sticky interlock fault flag
//   fault_clr        synchronous clear request for fault (a new violation wins)
// -----------------------------------------------------------------------------
module coil_pwm_driver #(
   parameter int PRESC_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [7:0] duty_a,
   input  logic [7:0] duty_b,
   input  logic [7:0] duty_c,
   input  logic [7:0] duty_d,
   input  logic       fault_clr,
   output logic       pwm_a,
   output logic       pwm_b,
   output logic       pwm_c,
   output logic       pwm_d,
   output logic       period_start,
   output logic       fault
);

   localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;

   logic [PW-1:0] presc_q,  presc_nxt;
   logic [7:0]    cnt_q,    cnt_nxt;
   logic [7:0]    shadow_a, shadow_a_nxt;
   logic [7:0]    shadow_b, shadow_b_nxt;
   logic [7:0]    shadow_c, shadow_c_nxt;
   logic [7:0]    shadow_d, shadow_d_nxt;
   logic          inh_ac,   inh_ac_nxt;
   logic          inh_bd,   inh_bd_nxt;
   logic          en_q;
   logic          tick;
   logic          load;
   logic          viol_ac;
   logic          viol_bd;
   logic          fault_nxt;
   logic          pwm_a_nxt, pwm_b_nxt, pwm_c_nxt, pwm_d_nxt;

   // A load happens on the first enabled edge after idle/reset, and on the
   // tick that wraps the period counter from 255 back to 0.
   always_comb begin
      tick    = en && (presc_q == PW'(PRESC_DIV - 1));
      load    = en && (!en_q || (tick && (cnt_q == 8'hFF)));
      viol_ac = load && (duty_a != 8'd0) && (duty_c != 8'd0);
      viol_bd = load && (duty_b != 8'd0) && (duty_d != 8'd0);
   end

   always_comb begin
      presc_nxt    = presc_q;
      cnt_nxt      = cnt_q;
      shadow_a_nxt = shadow_a;
      shadow_b_nxt = shadow_b;
      shadow_c_nxt = shadow_c;
      shadow_d_nxt = shadow_d;
      inh_ac_nxt   = inh_ac;
      inh_bd_nxt   = inh_bd;
      if (!en) begin
         presc_nxt    = '0;
         cnt_nxt      = '0;
         shadow_a_nxt = '0;
         shadow_b_nxt = '0;
         shadow_c_nxt = '0;
         shadow_d_nxt = '0;
         inh_ac_nxt   = 1'b0;
         inh_bd_nxt   = 1'b0;
      end else begin
         // A load edge is always a prescaler boundary: either the wrap tick
         // or the enable edge with the prescaler already idle at zero.
         if (tick || load) presc_nxt = '0;
         else              presc_nxt = presc_q + PW'(1);
         if (load)         cnt_nxt = '0;
         else if (tick)    cnt_nxt = cnt_q + 8'd1;
         if (load) begin
            shadow_a_nxt = duty_a;
            shadow_b_nxt = duty_b;
            shadow_c_nxt = duty_c;
            shadow_d_nxt = duty_d;
            inh_ac_nxt   = viol_ac;
            inh_bd_nxt   = viol_bd;
         end
      end
   end

   // Outputs are registered from the next-state counter/shadow values, so a
   // channel with nonzero duty rises in the same cycle as period_start.
   always_comb begin
      pwm_a_nxt = en && !inh_ac_nxt && (cnt_nxt < shadow_a_nxt);
      pwm_c_nxt = en && !inh_ac_nxt && (cnt_nxt < shadow_c_nxt);
      pwm_b_nxt = en && !inh_bd_nxt && (cnt_nxt < shadow_b_nxt);
      pwm_d_nxt = en && !inh_bd_nxt && (cnt_nxt < shadow_d_nxt);
      // A violation on the same edge as a clear request keeps the flag set.
      if (viol_ac || viol_bd) fault_nxt = 1'b1;
      else if (fault_clr)     fault_nxt = 1'b0;
      else                    fault_nxt = fault;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q      <= '0;
         cnt_q        <= '0;
         shadow_a     <= '0;
         shadow_b     <= '0;
         shadow_c     <= '0;
         shadow_d     <= '0;
         inh_ac       <= 1'b0;
         inh_bd       <= 1'b0;
         en_q         <= 1'b0;
         pwm_a        <= 1'b0;
         pwm_b        <= 1'b0;
         pwm_c        <= 1'b0;
         pwm_d        <= 1'b0;
         period_start <= 1'b0;
         fault        <= 1'b0;
      end else begin
         presc_q      <= presc_nxt;
         cnt_q        <= cnt_nxt;
         shadow_a     <= shadow_a_nxt;
         shadow_b     <= shadow_b_nxt;
         shadow_c     <= shadow_c_nxt;
         shadow_d     <= shadow_d_nxt;
         inh_ac       <= inh_ac_nxt;
         inh_bd       <= inh_bd_nxt;
         en_q         <= en;
         pwm_a        <= pwm_a_nxt;
         pwm_b        <= pwm_b_nxt;
         pwm_c        <= pwm_c_nxt;
         pwm_d        <= pwm_d_nxt;
         period_start <= load;
         fault        <= fault_nxt;
      end
   end

endmodule

// File: tb/tb_coil_pwm_driver.sv
// -----------------------------------------------------------------------------
// tb_coil_pwm_driver
//
// Bench for coil_pwm_driver with PRESC_DIV=4. The reference model tracks the
// position inside the current PWM period as a plain clk-cycle index k
// (0..256*P-1); a channel is expected high while k/P is below its latched
// duty, unless its pair was interlocked at the last load.
// -----------------------------------------------------------------------------
module tb_coil_pwm_driver;

   localparam int P      = 4;
   localparam int PERIOD = 256 * P;

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       fault_clr;
   logic [7:0] duty_a, duty_b, duty_c, duty_d;
   logic       pwm_a, pwm_b, pwm_c, pwm_d;
   logic       period_start;
   logic       fault;

   always #5 clk = ~clk;

   coil_pwm_driver #(.PRESC_DIV(P)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .duty_a       (duty_a),
      .duty_b       (duty_b),
      .duty_c       (duty_c),
      .duty_d       (duty_d),
      .fault_clr    (fault_clr),
      .pwm_a        (pwm_a),
      .pwm_b        (pwm_b),
      .pwm_c        (pwm_c),
      .pwm_d        (pwm_d),
      .period_start (period_start),
      .fault        (fault)
   );

   // ---------------- scoreboard counters ----------------
   int total = 0;
   int bad   = 0;
   int hi_dut[4];
   int hi_exp[4];
   int ps_dut;
   int mism;

   // ---------------- reference model ----------------
   bit m_run;
   int m_k;
   int m_sh[4];
   bit m_inh_ac, m_inh_bd;
   bit m_fault;
   bit m_ps;

   function automatic bit exp_pwm(int i);
      bit inh;
      inh = (i == 0 || i == 2) ? m_inh_ac : m_inh_bd;
      return m_run && !inh && ((m_k / P) < m_sh[i]);
   endfunction

   task automatic model_reset();
      m_run = 0; m_k = 0; m_inh_ac = 0; m_inh_bd = 0; m_fault = 0; m_ps = 0;
      for (int i = 0; i < 4; i++) m_sh[i] = 0;
   endtask

   task automatic model_edge();
      bit v;
      if (!en) begin
         m_run = 0; m_k = 0; m_inh_ac = 0; m_inh_bd = 0; m_ps = 0;
         for (int i = 0; i < 4; i++) m_sh[i] = 0;
         if (fault_clr) m_fault = 0;
      end else if (!m_run || m_k == PERIOD - 1) begin
         m_run = 1; m_k = 0; m_ps = 1;
         m_sh[0] = duty_a; m_sh[1] = duty_b; m_sh[2] = duty_c; m_sh[3] = duty_d;
         m_inh_ac = (duty_a != 0) && (duty_c != 0);
         m_inh_bd = (duty_b != 0) && (duty_d != 0);
         v = m_inh_ac || m_inh_bd;
         if (v) m_fault = 1;
         else if (fault_clr) m_fault = 0;
      end else begin
         m_k++; m_ps = 0;
         if (fault_clr) m_fault = 0;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_counts();
      for (int i = 0; i < 4; i++) begin hi_dut[i] = 0; hi_exp[i] = 0; end
      ps_dut = 0; mism = 0;
   endtask

   // One clk cycle: advance the model on the edge, sample the DUT 1 time unit later.
   task automatic step();
      logic [3:0] dv;
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      #1;
      dv = {pwm_d, pwm_c, pwm_b, pwm_a};
      for (int i = 0; i < 4; i++) begin
         if (dv[i] !== exp_pwm(i)) mism++;
         if (dv[i] === 1'b1) hi_dut[i]++;
         if (exp_pwm(i)) hi_exp[i]++;
      end
      if (period_start !== m_ps) mism++;
      if (fault !== m_fault) mism++;
      if (period_start === 1'b1) ps_dut++;
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Idle two cycles, load new duties, then enable; the next step is a load edge.
   task automatic restart(int a, int b, int c, int d);
      en = 0; fault_clr = 0;
      steps(2);
      duty_a = 8'(a); duty_b = 8'(b); duty_c = 8'(c); duty_d = 8'(d);
      en = 1;
      clear_counts();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1; en = 0; fault_clr = 0;
      duty_a = 0; duty_b = 0; duty_c = 0; duty_d = 0;
      model_reset();
      clear_counts();
      #2;
      total++;
      if ({pwm_a, pwm_b, pwm_c, pwm_d, period_start, fault} !== 6'b0) begin
         bad++; $display("FAIL reset_outputs: got %b want 000000",
                         {pwm_a, pwm_b, pwm_c, pwm_d, period_start, fault});
      end
      steps(3);
      rst = 0;
      steps(2);
      total++;
      if (mism !== 0) begin bad++; $display("FAIL reset_idle_mism: got %0d want 0", mism); end
   endtask

   task automatic test_basic();
      restart(64, 0, 0, 0);
      step();
      total++;
      if (period_start !== 1'b1 || pwm_a !== 1'b1) begin
         bad++; $display("FAIL basic_first_cycle: got ps=%b pwm_a=%b want ps=1 pwm_a=1", period_start, pwm_a);
      end
      steps(PERIOD - 1);
      total++;
      if (hi_dut[0] !== 256) begin bad++; $display("FAIL basic_hi_a: got %0d want 256", hi_dut[0]); end
      total++;
      if (ps_dut !== 1) begin bad++; $display("FAIL basic_ps_count: got %0d want 1", ps_dut); end
      total++;
      if (fault !== 1'b0) begin bad++; $display("FAIL basic_fault: got %b want 0", fault); end
      clear_counts();
      steps(PERIOD);
      total++;
      if (hi_dut[0] !== 256 || ps_dut !== 1) begin
         bad++; $display("FAIL basic_second_period: got hi=%0d ps=%0d want hi=256 ps=1", hi_dut[0], ps_dut);
      end
      total++;
      if (mism !== 0) begin bad++; $display("FAIL basic_mism: got %0d want 0", mism); end
   endtask

   task automatic test_extremes();
      int held;
      restart(0, 0, 0, 255);
      steps(PERIOD - 4);
      held = hi_dut[3];
      total++;
      if (held !== 1020) begin bad++; $display("FAIL ext_hi_d_before_255: got %0d want 1020", held); end
      steps(4);
      total++;
      if (hi_dut[3] !== 1020) begin bad++; $display("FAIL ext_d_low_at_255: got %0d want 1020", hi_dut[3]); end
      total++;
      if (hi_dut[1] !== 0) begin bad++; $display("FAIL ext_hi_b: got %0d want 0", hi_dut[1]); end
      total++;
      if (mism !== 0) begin bad++; $display("FAIL ext_mism: got %0d want 0", mism); end
   endtask

   task automatic test_duty_change();
      int m1;
      restart(64, 0, 0, 0);
      steps(20 * P);
      duty_a = 128;
      steps(PERIOD - 20 * P);
      total++;
      if (hi_dut[0] !== 256) begin bad++; $display("FAIL change_cur_period: got %0d want 256", hi_dut[0]); end
      m1 = mism;
      clear_counts();
      steps(PERIOD);
      total++;
      if (hi_dut[0] !== 512) begin bad++; $display("FAIL change_next_period: got %0d want 512", hi_dut[0]); end
      total++;
      if (mism + m1 !== 0) begin bad++; $display("FAIL change_mism: got %0d want 0", mism + m1); end
   endtask

   task automatic test_interlock();
      int m1;
      restart(10, 50, 10, 0);
      step();
      total++;
      if (fault !== 1'b1 || period_start !== 1'b1) begin
         bad++; $display("FAIL ilk_fault_set: got fault=%b ps=%b want 1 1", fault, period_start);
      end
      steps(PERIOD - 1);
      total++;
      if (hi_dut[0] !== 0 || hi_dut[2] !== 0) begin
         bad++; $display("FAIL ilk_ac_low: got a=%0d c=%0d want 0 0", hi_dut[0], hi_dut[2]);
      end
      total++;
      if (hi_dut[1] !== 200) begin bad++; $display("FAIL ilk_b_runs: got %0d want 200", hi_dut[1]); end
      m1 = mism;
      // Pending duty_c=0; clear the fault mid-period.
      clear_counts();
      duty_c = 0;
      steps(100);
      fault_clr = 1;
      step();
      fault_clr = 0;
      total++;
      if (fault !== 1'b0) begin bad++; $display("FAIL ilk_clear: got %b want 0", fault); end
      steps(PERIOD - 101);
      clear_counts();
      steps(PERIOD);
      total++;
      if (hi_dut[0] !== 40 || hi_dut[2] !== 0) begin
         bad++; $display("FAIL ilk_after_clear: got a=%0d c=%0d want 40 0", hi_dut[0], hi_dut[2]);
      end
      // Clear request on the same edge as a violating load: set wins.
      duty_c = 10;
      fault_clr = 1;
      step();
      fault_clr = 0;
      total++;
      if (fault !== 1'b1) begin bad++; $display("FAIL ilk_set_wins: got %b want 1", fault); end
      steps(PERIOD - 1);
      total++;
      if (mism + m1 !== 0) begin bad++; $display("FAIL ilk_mism: got %0d want 0", mism + m1); end
   endtask

   task automatic test_en_drop();
      restart(200, 0, 0, 0);
      steps(1 + 100 * P);
      en = 0;
      step();
      total++;
      if (pwm_a !== 1'b0 || period_start !== 1'b0) begin
         bad++; $display("FAIL endrop_low: got pwm_a=%b ps=%b want 0 0", pwm_a, period_start);
      end
      total++;
      if (fault !== 1'b1) begin bad++; $display("FAIL endrop_fault_kept: got %b want 1", fault); end
      steps(4);
      en = 1;
      clear_counts();
      step();
      total++;
      if (period_start !== 1'b1 || pwm_a !== 1'b1) begin
         bad++; $display("FAIL enrise_load: got ps=%b pwm_a=%b want 1 1", period_start, pwm_a);
      end
      steps(PERIOD - 1);
      total++;
      if (hi_dut[0] !== 800) begin bad++; $display("FAIL enrise_pulse: got %0d want 800", hi_dut[0]); end
      total++;
      if (mism !== 0) begin bad++; $display("FAIL endrop_mism: got %0d want 0", mism); end
   endtask

   task automatic test_async_reset();
      steps(10);
      #2;
      rst = 1;
      #1;
      total++;
      if ({pwm_a, pwm_b, pwm_c, pwm_d, period_start, fault} !== 6'b0) begin
         bad++; $display("FAIL async_reset: got %b want 000000",
                         {pwm_a, pwm_b, pwm_c, pwm_d, period_start, fault});
      end
      model_reset();
      step();
      rst = 0;
      clear_counts();
      step();
      total++;
      if (period_start !== 1'b1 || pwm_a !== 1'b1) begin
         bad++; $display("FAIL async_first_load: got ps=%b pwm_a=%b want 1 1", period_start, pwm_a);
      end
      steps(PERIOD - 1);
      total++;
      if (hi_dut[0] !== 800) begin bad++; $display("FAIL async_pulse: got %0d want 800", hi_dut[0]); end
      total++;
      if (mism !== 0) begin bad++; $display("FAIL async_mism: got %0d want 0", mism); end
   endtask

   task automatic test_random();
      restart($urandom_range(0, 255), 0, 0, $urandom_range(0, 255));
      for (int n = 0; n < 8000; n++) begin
         if ($urandom_range(0, 150) == 0) duty_a = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         if ($urandom_range(0, 150) == 0) duty_b = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         if ($urandom_range(0, 150) == 0) duty_c = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         if ($urandom_range(0, 150) == 0) duty_d = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         fault_clr = ($urandom_range(0, 40) == 0);
         if (!en) en = ($urandom_range(0, 3) == 0);
         else     en = ($urandom_range(0, 1500) != 0);
         step();
      end
      fault_clr = 0;
      total++;
      if (mism !== 0) begin bad++; $display("FAIL random_mism: got %0d want 0", mism); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (hi_dut[i] !== hi_exp[i]) begin
            bad++; $display("FAIL random_hi_%0d: got %0d want %0d", i, hi_dut[i], hi_exp[i]);
         end
      end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_duty_change();
      test_interlock();
      test_en_drop();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
